cla_wide_add_seq: RTL and testbench

Multi-precision add sequencer that sits directly upstream of the 32-bit CLA full adder and drives its `a_i`, `b_i` and `carry_i` inputs. It performs one wide addition of `32*WORDS` bits by presenting one 32-bit word slice per step, least significant first, and chaining the adder's `carry_o` into the next slice. It collects the adder's `sum_o` words and returns the complete wide sum and final carry with a one-cycle completion pulse.

---
 rtl/cla_wide_add_seq.sv | 161 ++++++++++++++++
 tb/tb_cla_wide_add_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_wide_add_seq.sv
// Multi-precision add sequencer: feeds a 32-bit adder one word slice per step,
// chains its carry between slices and returns the assembled wide sum.
module cla_wide_add_seq #(
    parameter int unsigned WORDS   = 4,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  aresetn_i,
    input  logic                  start_i,
    input  logic [32*WORDS-1:0]   a_i,
    input  logic [32*WORDS-1:0]   b_i,
    input  logic                  carry_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [32*WORDS-1:0]   sum_o,
    output logic                  carry_o,
    output logic [31:0]           add_a_o,
    output logic [31:0]           add_b_o,
    output logic                  add_carry_o,
    input  logic [31:0]           add_sum_i,
    input  logic                  add_carry_i
);

    localparam int unsigned W     = 32 * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned LAT_W = $clog2(ADD_LAT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ADD_LAT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [LAT_W-1:0]   lat_q,    lat_d;
    logic [W-1:0]       opa_q,    opa_d;
    logic [W-1:0]       opb_q,    opb_d;
    logic               cy_q,     cy_d;
    logic [W-1:0]       shadow_q, shadow_d;
    logic [W-1:0]       sum_q,    sum_d;
    logic               carry_q,  carry_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [31:0]        add_a_q,  add_a_d;
    logic [31:0]        add_b_q,  add_b_d;
    logic               add_cy_q, add_cy_d;
    logic [IDX_W-1:0]   idx_nxt;

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        cy_d     = cy_q;
        shadow_d = shadow_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        add_cy_d = add_cy_q;
        idx_nxt  = IDX_W'(idx_q + 1'b1);

        case (state_q)
            S_IDLE: begin
                add_a_d  = '0;
                add_b_d  = '0;
                add_cy_d = 1'b0;
                if (start_i) begin
                    state_d  = S_RUN;
                    opa_d    = a_i;
                    opb_d    = b_i;
                    cy_d     = carry_i;
                    idx_d    = '0;
                    lat_d    = '0;
                    busy_d   = 1'b1;
                    add_a_d  = a_i[31:0];
                    add_b_d  = b_i[31:0];
                    add_cy_d = carry_i;
                end
            end
            S_RUN: begin
                if (lat_q != LAT_LAST) begin
                    lat_d = LAT_W'(lat_q + 1'b1);
                end else begin
                    lat_d = '0;
                    cy_d  = add_carry_i;
                    shadow_d[{idx_q, 5'd0} +: 32] = add_sum_i;
                    if (idx_q == IDX_LAST) begin
                        // Top word bypasses the shadow so the result lands atomically
                        state_d  = S_IDLE;
                        sum_d    = shadow_q;
                        sum_d[W-1 -: 32] = add_sum_i;
                        carry_d  = add_carry_i;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        add_a_d  = '0;
                        add_b_d  = '0;
                        add_cy_d = 1'b0;
                    end else begin
                        idx_d    = idx_nxt;
                        add_a_d  = opa_q[{idx_nxt, 5'd0} +: 32];
                        add_b_d  = opb_q[{idx_nxt, 5'd0} +: 32];
                        add_cy_d = add_carry_i;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            lat_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cy_q     <= 1'b0;
            shadow_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_cy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cy_q     <= cy_d;
            shadow_q <= shadow_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            add_cy_q <= add_cy_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign sum_o       = sum_q;
    assign carry_o     = carry_q;
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign add_carry_o = add_cy_q;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Scoreboard bench for cla_wide_add_seq: default instance plus a WORDS=2/ADD_LAT=2
// instance, each driving a registered behavioural adder of matching latency.
module tb_cla_wide_add_seq;

    localparam int unsigned W0 = 4, L0 = 1, W1 = 2, L1 = 2;
    localparam int unsigned D0 = W0 * (L0 + 1);
    localparam int unsigned D1 = W1 * (L1 + 1);

    typedef struct {
        logic [128:0] val;
        int unsigned  cyc;
    } exp_t;

    logic clk = 1'b0;
    logic aresetn;
    int unsigned cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default instance
    logic          start0, c0, busy0, done0, co0, ac0, asc0;
    logic [127:0]  a0, b0, sum0;
    logic [31:0]   aa0, ab0, as0;
    logic [32:0]   p0;

    cla_wide_add_seq #(.WORDS(W0), .ADD_LAT(L0)) dut0 (
        .clk_i(clk), .aresetn_i(aresetn), .start_i(start0), .a_i(a0), .b_i(b0),
        .carry_i(c0), .busy_o(busy0), .done_o(done0), .sum_o(sum0), .carry_o(co0),
        .add_a_o(aa0), .add_b_o(ab0), .add_carry_o(ac0), .add_sum_i(as0), .add_carry_i(asc0)
    );

    always @(posedge clk) p0 <= {1'b0, aa0} + {1'b0, ab0} + 33'(ac0);
    assign as0  = p0[31:0];
    assign asc0 = p0[32];

    // Second instance, two-stage adder
    logic          start1, c1, busy1, done1, co1, ac1, asc1;
    logic [63:0]   a1, b1, sum1;
    logic [31:0]   aa1, ab1, as1;
    logic [65:0]   p1;

    cla_wide_add_seq #(.WORDS(W1), .ADD_LAT(L1)) dut1 (
        .clk_i(clk), .aresetn_i(aresetn), .start_i(start1), .a_i(a1), .b_i(b1),
        .carry_i(c1), .busy_o(busy1), .done_o(done1), .sum_o(sum1), .carry_o(co1),
        .add_a_o(aa1), .add_b_o(ab1), .add_carry_o(ac1), .add_sum_i(as1), .add_carry_i(asc1)
    );

    always @(posedge clk) p1 <= {p1[32:0], {1'b0, aa1} + {1'b0, ab1} + 33'(ac1)};
    assign as1  = p1[64:33];
    assign asc1 = p1[65];

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int errors = 0;
    int checks = 0;
    int done_cnt0 = 0;
    int busy_len0 = 0;
    int busy_len1 = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got done_o=1, expected no completion", name);
    endtask

    // Monitor for the default instance
    always @(negedge clk) begin
        if (!aresetn) begin
            busy_len0 = 0;
        end else begin
            if (done0) begin
                done_cnt0++;
                if (q0.size() == 0) begin
                    unexpected("dut0 spurious done");
                end else begin
                    e0 = q0.pop_front();
                    chk("dut0 result", 256'({co0, sum0}), 256'(e0.val));
                    chk("dut0 done edge", 256'(cyc), 256'(e0.cyc));
                end
            end
            if (busy0) begin
                busy_len0++;
            end else if (busy_len0 != 0) begin
                chk("dut0 busy length", 256'(busy_len0), 256'(D0));
                busy_len0 = 0;
            end
        end
    end

    // Monitor for the second instance
    always @(negedge clk) begin
        if (!aresetn) begin
            busy_len1 = 0;
        end else begin
            if (done1) begin
                if (q1.size() == 0) begin
                    unexpected("dut1 spurious done");
                end else begin
                    e1 = q1.pop_front();
                    chk("dut1 result", 256'({co1, sum1}), 256'(e1.val));
                    chk("dut1 done edge", 256'(cyc), 256'(e1.cyc));
                end
            end
            if (busy1) begin
                busy_len1++;
            end else if (busy_len1 != 0) begin
                chk("dut1 busy length", 256'(busy_len1), 256'(D1));
                busy_len1 = 0;
            end
        end
    end

    // Called #1 after a rising edge with the sequencer idle (or in its done cycle)
    task automatic start_op0(input logic [127:0] a, input logic [127:0] b,
                             input logic c, input logic [128:0] exp);
        start0 = 1'b1; a0 = a; b0 = b; c0 = c;
        @(posedge clk); #1;
        start0 = 1'b0;
        q0.push_back('{val: exp, cyc: cyc + D0});
    endtask

    task automatic start_op1(input logic [63:0] a, input logic [63:0] b, input logic c);
        start1 = 1'b1; a1 = a; b1 = b; c1 = c;
        @(posedge clk); #1;
        start1 = 1'b0;
        q1.push_back('{val: 129'({1'b0, a} + {1'b0, b} + 65'(c)), cyc: cyc + D1});
    endtask

    task automatic wait_done0();
        int n = 0;
        while (!done0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done0) begin
            checks++; errors++;
            $display("FAIL dut0 done timeout: got no done_o in %0d cycles, expected one", n);
        end
    endtask

    task automatic wait_done1();
        int n = 0;
        while (!done1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done1) begin
            checks++; errors++;
            $display("FAIL dut1 done timeout: got no done_o in %0d cycles, expected one", n);
        end
    endtask

    logic [127:0] ones, p96;
    int dcnt;

    initial begin
        ones = '1;
        p96  = 128'(1) << 96;
        aresetn = 1'b0;
        start0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dut0 outputs", 256'({busy0, done0, co0, sum0, aa0, ab0, ac0}), 256'(0));
        chk("reset dut1 outputs", 256'({busy1, done1, co1, sum1, aa1, ab1, ac1}), 256'(0));
        aresetn = 1'b1;
        @(posedge clk); #1;

        start_op0(128'd1, 128'd2, 1'b0, 129'd3);
        wait_done0();
        start_op0(ones, 128'd1, 1'b0, {1'b1, 128'd0});
        wait_done0();
        start_op0(128'd0, 128'd0, 1'b1, 129'd1);
        wait_done0();
        start_op0(ones, ones, 1'b1, {1'b1, ones});
        wait_done0();
        @(posedge clk); #1;
        chk("idle adder drive", 256'({aa0, ab0, ac0}), 256'(0));

        // start while busy is ignored; operands changing mid-op have no effect
        start_op0(128'd5, 128'd7, 1'b0, 129'd12);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start0 = 1'b1; a0 = 128'd9; b0 = 128'd9;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done0();
        start_op0(128'd9, 128'd9, 1'b0, 129'd18);
        wait_done0();

        // abort mid-operation with reset
        start_op0(p96, p96, 1'b0, 129'(p96) << 1);
        repeat (5) @(posedge clk);
        #1;
        aresetn = 1'b0;
        q0.delete();
        #1;
        chk("abort clears outputs", 256'({busy0, done0, co0, sum0, aa0, ab0, ac0}), 256'(0));
        dcnt = done_cnt0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no done after abort", 256'(done_cnt0), 256'(dcnt));
        start_op0(128'd3, 128'd4, 1'b0, 129'd7);
        wait_done0();
        @(posedge clk); #1;

        for (int i = 0; i < 200; i++) begin
            start_op1({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            wait_done1();
        end
        start_op1(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        wait_done1();

        repeat (4) @(posedge clk);
        #1;
        chk("dut0 queue drained", 256'(q0.size()), 256'(0));
        chk("dut1 queue drained", 256'(q1.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
